ethernet_icmp_tx_checksum_inserter: RTL and testbench
=====================================================

# ethernet_icmp_tx_checksum_inserter

Store-and-forward stage on the 64-bit AXI-Stream transmit path that computes the ICMP checksum of an outgoing IPv4/ICMP Ethernet frame and writes it into the ICMP checksum field before the frame leaves. The upstream reply builder emits frames with an arbitrary value in the checksum field. This block buffers one whole frame, sums it in one's-complement arithmetic, then replays it to the MAC transmit interface with bytes 36–37 replaced. It is the transmit-side counterpart of the receive-path ICMP checksum counter.

## Interface
Parameters:
- DEPTH_LOG2, 8: log2 of frame buffer depth in 64-bit beats. 256 beats covers 2048 bytes.

Ports:
- i_clk  in  1  clock.
- i_reset_n  in  1  asynchronous, active-low reset.
- s_axis_tdata  in  64  frame data; byte n of the beat is on [8n+7:8n]. Byte 0 is first on the wire.
- s_axis_tkeep  in  8  byte enables.
- s_axis_tlast  in  1  last beat of frame.
- s_axis_tvalid  in  1  input beat valid.
- s_axis_tready  out  1  block accepts an input beat.
- m_axis_tdata  out  64  output data.
- m_axis_tkeep  out  8  output byte enables; equal to the input tkeep of the same beat.
- m_axis_tlast  out  1  output last beat.
- m_axis_tvalid  out  1  output beat valid.
- m_axis_tready  in  1  downstream accepts a beat.
- o_icmp_csum  out  16  last inserted checksum; holds until the next insertion.
- o_icmp_csum_valid  out  1  one-cycle pulse when o_icmp_csum updates.
- o_drop  out  1  one-cycle pulse when an oversize frame is discarded.

## Operation
- States:
  - RECV (state after reset, s_axis_tready=1).
  - FOLD1 and FOLD2 (s_axis_tready=0).
  - SEND (s_axis_tready=0).
  - DISCARD (s_axis_tready=1).
- Frame layout: fixed offsets, no VLAN tag, IHL=5. The ICMP header starts at byte 34. The checksum field is bytes 36–37, which is beat 4 lanes 4 and 5.
- Summation, in RECV:
  - Each accepted beat writes to the buffer at the beat counter address.
  - Lane pairs {lane 2k, lane 2k+1} form big-endian 16-bit words. Lane 2k is the high byte.
  - Bytes with tkeep=0 count as 0x00, so an odd trailing byte is padded low.
  - Summed bytes: beat 4 lanes 2,3,6,7, and all lanes of beats 5 and later. Beat 4 lanes 4,5 count as zero whatever their content. Beats 0–3 are not summed.
  - The accumulator is 32 bits, unsigned, with no folding during receive.
- Oversize frame: if a beat arrives with the counter at 2^DEPTH_LOG2 and tlast=0, go to DISCARD. Accept and drop beats until tlast. Pulse o_drop on the tlast beat, then return to RECV. Nothing is emitted for that frame.
- On the tlast handshake in RECV, go to FOLD1.
- Fold and invert:
  - FOLD1: t = acc[15:0] + acc[31:16], 17 bits.
  - FOLD2: csum = ~(t[15:0] + t[16]).
  - A result of 0x0000 is inserted as-is.
- Runt frame: if tlast arrives before beat 4, the frame is forwarded unmodified and o_icmp_csum_valid does not pulse.
- SEND:
  - Beats are replayed in order. Beat 4 carries csum[15:8] on lane 4 and csum[7:0] on lane 5; all other bytes are unchanged.
  - After the tlast handshake, clear the counter and accumulator and return to RECV.

## Timing
- Reset values: s_axis_tready=0 while i_reset_n=0 and 1 from the first clock after release. m_axis_tvalid=0, m_axis_tdata/tkeep/tlast=0, o_icmp_csum=0x0000, o_icmp_csum_valid=0, o_drop=0.
- With the tlast handshake at edge T: FOLD1 at T+1, FOLD2 at T+2.
- m_axis_tvalid=1 with beat 0 presented from T+3. o_icmp_csum and o_icmp_csum_valid update at the same edge.
- Buffer reads are synchronous. The beat-0 read is issued during FOLD2; each later read is issued on an output handshake. Throughput is one beat per cycle while m_axis_tready=1.
- AXI-Stream rules: m_axis_tvalid and data stay stable until m_axis_tready=1. m_axis_tvalid never depends combinationally on m_axis_tready.
- s_axis_tready=1 again on the cycle after the output tlast handshake.
- An asynchronous reset at any point aborts the frame: buffer contents are discarded and all outputs return to reset values.

## Configuration
- ICMP_TX_CSUM_PROTO_CHECK_EN defined:
  - Insertion happens only if EtherType (bytes 12–13) = 0x0800, byte 14 = 0x45, and the protocol byte (byte 23) = 0x01.
  - Any other frame is forwarded unmodified with no o_icmp_csum_valid pulse.
- Not defined: every frame of at least 5 beats gets insertion.

## Test plan
- Echo reply: 42-byte frame with ICMP bytes 00 00 AA BB 12 34 00 01. Beat 5 has tkeep=0x03. Expect output bytes 36–37 = ED CA, o_icmp_csum=0xEDCA with one valid pulse, and every other byte identical. tvalid appears 3 cycles after the input tlast.
- Carry fold: same frame plus payload FF FF FF FF (46 bytes, beat 5 tkeep=0x3F). Expect checksum 0xEDCA, since 0x21233 folds to 0x1235.
- Odd length: 43-byte frame with trailing byte 0x80. Expect checksum 0x6DCA.
- Backpressure: m_axis_tready toggles 1,0,0,1 repeatedly. Expect no lost, duplicated or changed beats, and s_axis_tready=0 until the last output beat is accepted.
- Oversize with DEPTH_LOG2=3: send a 9-beat frame, then a valid 42-byte frame. Expect one o_drop pulse and no output for the first frame; the second frame gets 0xEDCA.
- Reset mid-SEND: deassert i_reset_n after beat 2 is output. Expect all outputs at reset values immediately, and the next frame processed correctly.

Source files
------------

// File: rtl/ethernet_icmp_tx_checksum_inserter.sv
// Store-and-forward ICMP checksum inserter: buffers one frame, sums the ICMP bytes, replays it with bytes 36-37 replaced.
// Optional macro ICMP_TX_CSUM_PROTO_CHECK_EN restricts insertion to IPv4 (IHL=5) ICMP frames.
module ethernet_icmp_tx_checksum_inserter #(
  parameter int DEPTH_LOG2 = 8
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic [63:0] s_axis_tdata,
  input  logic [7:0]  s_axis_tkeep,
  input  logic        s_axis_tlast,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  output logic [63:0] m_axis_tdata,
  output logic [7:0]  m_axis_tkeep,
  output logic        m_axis_tlast,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic [15:0] o_icmp_csum,
  output logic        o_icmp_csum_valid,
  output logic        o_drop
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;

  typedef enum logic [2:0] {RECV, FOLD1, FOLD2, SEND, DISCARD} state_t;
  state_t r_state, w_nxt;

  logic [72:0]   r_mem [DEPTH];
  logic [CW-1:0] r_cnt, r_rd;
  logic [31:0]   r_acc;
  logic [16:0]   r_t;
  logic          r_ins, r_tready;
  logic          w_s_hs, w_m_hs, w_full, w_wr, w_load, w_proto_ok;
  logic [7:0]    w_b [8];
  logic [15:0]   w_w [4];
  logic [17:0]   w_sum;
  logic [72:0]   w_rd;
  logic [63:0]   w_rd_data;
  logic [15:0]   w_csum;

  assign s_axis_tready = r_tready;
  assign w_s_hs = s_axis_tvalid & r_tready;
  assign w_m_hs = m_axis_tvalid & m_axis_tready;
  assign w_full = r_cnt[DEPTH_LOG2];
  assign w_wr   = (r_state == RECV) & w_s_hs & ~w_full;
  assign w_load = (r_state == FOLD2) | ((r_state == SEND) & w_m_hs & ~m_axis_tlast);
  assign w_csum = ~(r_t[15:0] + {15'd0, r_t[16]});

`ifdef ICMP_TX_CSUM_PROTO_CHECK_EN
  logic r_eth_ok, r_ip_ok;
  assign w_proto_ok = r_eth_ok & r_ip_ok;
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_eth_ok <= 1'b0;
      r_ip_ok  <= 1'b0;
    end else if (w_wr) begin
      if (r_cnt == CW'(1))
        r_eth_ok <= (s_axis_tdata[39:32] == 8'h08) && (s_axis_tdata[47:40] == 8'h00) &&
                    (s_axis_tdata[55:48] == 8'h45);
      if (r_cnt == CW'(2))
        r_ip_ok <= (s_axis_tdata[63:56] == 8'h01);
    end
  end
`else
  assign w_proto_ok = 1'b1;
`endif

  // Beat 4 lanes 0-1 are IP header and lanes 4-5 the checksum field itself; both are left out.
  always_comb begin
    for (int l = 0; l < 8; l++) w_b[l] = s_axis_tkeep[l] ? s_axis_tdata[8*l +: 8] : 8'h00;
    for (int k = 0; k < 4; k++) w_w[k] = {w_b[2*k], w_b[2*k+1]};
    w_sum = '0;
    if (r_cnt >= CW'(4)) w_sum = w_sum + {2'b0, w_w[1]} + {2'b0, w_w[3]};
    if (r_cnt >= CW'(5)) w_sum = w_sum + {2'b0, w_w[0]} + {2'b0, w_w[2]};
  end

  always_comb begin
    w_rd      = r_mem[r_rd[DEPTH_LOG2-1:0]];
    w_rd_data = w_rd[63:0];
    if (r_ins && r_rd == CW'(4)) w_rd_data[47:32] = {o_icmp_csum[7:0], o_icmp_csum[15:8]};
  end

  always_ff @(posedge i_clk) begin
    if (w_wr) r_mem[r_cnt[DEPTH_LOG2-1:0]] <= {s_axis_tlast, s_axis_tkeep, s_axis_tdata};
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) r_state <= RECV;
    else            r_state <= w_nxt;
  end

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      RECV:    if (w_s_hs) begin
                 if (w_full) w_nxt = s_axis_tlast ? RECV : DISCARD;
                 else if (s_axis_tlast) w_nxt = FOLD1;
               end
      FOLD1:   w_nxt = FOLD2;
      FOLD2:   w_nxt = SEND;
      SEND:    if (w_m_hs && m_axis_tlast) w_nxt = RECV;
      DISCARD: if (w_s_hs && s_axis_tlast) w_nxt = RECV;
      default: w_nxt = RECV;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_tready          <= 1'b0;
      r_cnt             <= '0;
      r_rd              <= '0;
      r_acc             <= '0;
      r_t               <= '0;
      r_ins             <= 1'b0;
      m_axis_tdata      <= '0;
      m_axis_tkeep      <= '0;
      m_axis_tlast      <= 1'b0;
      m_axis_tvalid     <= 1'b0;
      o_icmp_csum       <= '0;
      o_icmp_csum_valid <= 1'b0;
      o_drop            <= 1'b0;
    end else begin
      r_tready          <= (w_nxt == RECV) || (w_nxt == DISCARD);
      o_icmp_csum_valid <= 1'b0;
      o_drop            <= 1'b0;
      if (w_load) begin
        m_axis_tdata <= w_rd_data;
        m_axis_tkeep <= w_rd[71:64];
        m_axis_tlast <= w_rd[72];
        r_rd         <= r_rd + CW'(1);
      end
      case (r_state)
        RECV: if (w_s_hs) begin
          if (w_full) begin
            if (s_axis_tlast) begin
              o_drop <= 1'b1;
              r_cnt  <= '0;
              r_acc  <= '0;
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
            r_acc <= r_acc + 32'(w_sum);
            if (s_axis_tlast) r_ins <= (r_cnt >= CW'(4)) & w_proto_ok;
          end
        end
        FOLD1: r_t <= {1'b0, r_acc[15:0]} + {1'b0, r_acc[31:16]};
        FOLD2: begin
          m_axis_tvalid <= 1'b1;
          if (r_ins) begin
            o_icmp_csum       <= w_csum;
            o_icmp_csum_valid <= 1'b1;
          end
        end
        SEND: if (w_m_hs && m_axis_tlast) begin
          m_axis_tvalid <= 1'b0;
          r_cnt         <= '0;
          r_rd          <= '0;
          r_acc         <= '0;
          r_ins         <= 1'b0;
        end
        DISCARD: if (w_s_hs && s_axis_tlast) begin
          o_drop <= 1'b1;
          r_cnt  <= '0;
          r_acc  <= '0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_ethernet_icmp_tx_checksum_inserter.sv
// Bench for the ICMP checksum inserter: table vectors, hand sequences and random frames against a byte-level model.
module tb_ethernet_icmp_tx_checksum_inserter;
  localparam int DL2 = 3;

  typedef logic [7:0] bytes_t[$];
  typedef struct packed { logic [63:0] d; logic [7:0] k; logic l; } beat_t;
  typedef beat_t beats_t[$];
  typedef struct { string nm; int len; logic [63:0] icmp; logic [15:0] exp_c; bit exp_v; } vec_t;

  logic clk = 1'b0, rst_n = 1'b0;
  logic [63:0] s_tdata = '0;
  logic [7:0]  s_tkeep = '0;
  logic        s_tlast = 1'b0, s_tvalid = 1'b0, s_tready;
  logic [63:0] m_tdata;
  logic [7:0]  m_tkeep;
  logic        m_tlast, m_tvalid, m_tready = 1'b1;
  logic [15:0] csum;
  logic        csum_v, drop;

  ethernet_icmp_tx_checksum_inserter #(.DEPTH_LOG2(DL2)) dut (
    .i_clk(clk), .i_reset_n(rst_n),
    .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tlast(s_tlast),
    .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
    .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tlast(m_tlast),
    .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
    .o_icmp_csum(csum), .o_icmp_csum_valid(csum_v), .o_drop(drop)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, got, exp);
  endtask

  task automatic timeout(input string nm);
    n_chk++;
    $display("FAIL %s: timed out", nm);
  endtask

  // Output monitor, sampling on the falling edge.
  beat_t outq[$];
  int n_pulse, n_drop_p, stab_err, trdy_err, first_vld;
  logic [15:0] last_csum;
  bit got_last, prev_stall;
  beat_t prev_b;
  initial forever begin
    @(negedge clk);
    if (!rst_n) prev_stall = 0;
    else begin
      if (prev_stall && !(m_tvalid && m_tdata == prev_b.d && m_tkeep == prev_b.k && m_tlast == prev_b.l))
        stab_err++;
      prev_stall = m_tvalid && !m_tready;
      prev_b = '{m_tdata, m_tkeep, m_tlast};
      if (m_tvalid && m_tready) begin
        outq.push_back(prev_b);
        if (m_tlast) got_last = 1;
      end
      if (m_tvalid && s_tready) trdy_err++;
      if (m_tvalid && first_vld < 0) first_vld = cyc;
      if (csum_v) begin n_pulse++; last_csum = csum; end
      if (drop) n_drop_p++;
    end
  end

  // Downstream ready: 0 always-ready, 1 pattern 1,0,0,1, 2 random.
  int rdy_mode = 0, rph = 0;
  initial forever begin
    @(posedge clk); #1;
    case (rdy_mode)
      1: begin m_tready = (rph == 0 || rph == 3); rph = (rph + 1) % 4; end
      2: m_tready = 1'($urandom_range(0, 1));
      default: m_tready = 1'b1;
    endcase
  end

  function automatic bytes_t mk_frame(input int len, input logic [63:0] icmp);
    bytes_t b;
    b = {};
    for (int i = 0; i < len; i++) begin
      logic [7:0] v;
      v = 8'(i * 7 + 3);
      case (i)
        12: v = 8'h08; 13: v = 8'h00; 14: v = 8'h45; 23: v = 8'h01;
        34: v = 8'h00; 35: v = 8'h00; 36: v = 8'hAA; 37: v = 8'hBB;
        default: if (i >= 38 && i < 46) v = icmp[8*(45-i) +: 8];
      endcase
      b.push_back(v);
    end
    return b;
  endfunction

  // Disabled lanes carry junk so masking is exercised.
  task automatic make_beats(input bytes_t b, output beats_t bq);
    int nb;
    nb = (b.size() + 7) / 8;
    bq = {};
    for (int k = 0; k < nb; k++) begin
      beat_t x;
      x.d = {$urandom, $urandom};
      x.k = '0;
      for (int l = 0; l < 8; l++)
        if (k*8 + l < b.size()) begin x.d[8*l +: 8] = b[k*8 + l]; x.k[l] = 1'b1; end
      x.l = (k == nb - 1);
      bq.push_back(x);
    end
  endtask

  // RFC 1071 style: 16-bit big-endian words from byte 34, checksum field skipped, end-around carry.
  function automatic logic [15:0] ref_csum(input bytes_t b);
    int unsigned s;
    logic [15:0] r;
    s = 0;
    for (int i = 34; i < b.size(); i += 2)
      if (i != 36) s += {b[i], (i + 1 < b.size()) ? b[i+1] : 8'h00};
    while ((s >> 16) != 0) s = (s & 32'hFFFF) + (s >> 16);
    r = s[15:0];
    return ~r;
  endfunction

  task automatic send_beats(input beats_t bq, output int hs_cyc);
    hs_cyc = 0;
    @(posedge clk); #1;
    foreach (bq[i]) begin
      int w;
      w = 0;
      s_tvalid = 1'b1; s_tdata = bq[i].d; s_tkeep = bq[i].k; s_tlast = bq[i].l;
      @(negedge clk);
      while (!s_tready && w < 200) begin @(negedge clk); w++; end
      if (w >= 200) begin timeout("s_tready_wait"); break; end
      @(posedge clk); #1;
      hs_cyc = cyc;
    end
    s_tvalid = 1'b0; s_tlast = 1'b0;
  endtask

  task automatic clear_mon();
    outq = {}; n_pulse = 0; n_drop_p = 0; stab_err = 0; trdy_err = 0; first_vld = -1; got_last = 0;
  endtask

  task automatic run_frame(input bytes_t b, input string nm);
    beats_t bq, eq;
    int hs, t;
    logic [15:0] ec;
    bit ins;
    make_beats(b, bq);
    ins = b.size() > 32;
    ec  = ref_csum(b);
    eq  = bq;
    if (ins) begin eq[4].d[39:32] = ec[15:8]; eq[4].d[47:40] = ec[7:0]; end
    clear_mon();
    send_beats(bq, hs);
    t = 0;
    while (!got_last && t < 500) begin @(negedge clk); #1; t++; end
    if (!got_last) timeout({nm, "_out_last"});
    @(posedge clk); @(negedge clk);
    chk({nm, "_tready_after"}, 64'(s_tready), 64'd1);
    chk({nm, "_nbeats"}, 64'(outq.size()), 64'(eq.size()));
    foreach (eq[i])
      if (i < outq.size()) begin
        chk($sformatf("%s_b%0d_data", nm, i), outq[i].d, eq[i].d);
        chk($sformatf("%s_b%0d_keeplast", nm, i), 64'({outq[i].k, outq[i].l}), 64'({eq[i].k, eq[i].l}));
      end
    // Counted in rising edges: valid is registered two edges after the tlast handshake edge,
    // so it is presented in the third cycle after the tlast cycle.
    chk({nm, "_latency"}, 64'(first_vld - hs), 64'd2);
    chk({nm, "_pulses"}, 64'(n_pulse), 64'(ins));
    if (ins) chk({nm, "_csum"}, 64'(last_csum), 64'(ec));
    chk({nm, "_stability"}, 64'(stab_err), 64'd0);
    chk({nm, "_tready_busy"}, 64'(trdy_err), 64'd0);
    chk({nm, "_nodrop"}, 64'(n_drop_p), 64'd0);
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_s_tready"}, 64'(s_tready), 64'd0);
    chk({nm, "_m_tvalid"}, 64'(m_tvalid), 64'd0);
    chk({nm, "_m_tdata"}, m_tdata, 64'd0);
    chk({nm, "_m_keeplast"}, 64'({m_tkeep, m_tlast}), 64'd0);
    chk({nm, "_csum"}, 64'(csum), 64'd0);
    chk({nm, "_pulses"}, 64'({csum_v, drop}), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  vec_t tbl[7];
  initial begin
    beats_t bq;
    bytes_t b;
    int hs, t;
    tbl[0] = '{"echo",      42, 64'h1234_0001_0000_0000, 16'hEDCA, 1'b1};
    tbl[1] = '{"carry",     46, 64'h1234_0001_FFFF_FFFF, 16'hEDCA, 1'b1};
    tbl[2] = '{"odd",       43, 64'h1234_0001_8000_0000, 16'h6DCA, 1'b1};
    tbl[3] = '{"zero",      40, 64'hFFFF_0000_0000_0000, 16'h0000, 1'b1};
    tbl[4] = '{"five_beat", 40, 64'h1234_0000_0000_0000, 16'hEDCB, 1'b1};
    tbl[5] = '{"beat4_1b",  33, 64'h0,                   16'hFFFF, 1'b1};
    tbl[6] = '{"runt32",    32, 64'h0,                   16'h0000, 1'b0};

    #12;
    chk_reset_vals("reset");
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("tready_after_reset", 64'(s_tready), 64'd1);

    for (int i = 0; i < 7; i++) begin
      run_frame(mk_frame(tbl[i].len, tbl[i].icmp), tbl[i].nm);
      chk({tbl[i].nm, "_tbl_pulse"}, 64'(n_pulse), 64'(tbl[i].exp_v));
      if (tbl[i].exp_v) chk({tbl[i].nm, "_tbl_csum"}, 64'(last_csum), 64'(tbl[i].exp_c));
    end

    // Backpressure 1,0,0,1.
    rdy_mode = 1; rph = 0;
    run_frame(mk_frame(46, 64'h1234_0001_FFFF_FFFF), "bp_carry");
    chk("bp_carry_tbl_csum", 64'(last_csum), 64'hEDCA);
    rdy_mode = 0;

    // Oversize: 9 beats ends exactly on the full counter, 12 beats goes through discard.
    for (int n = 9; n <= 12; n += 3) begin
      b = {};
      for (int i = 0; i < n*8; i++) b.push_back(8'($urandom));
      make_beats(b, bq);
      clear_mon();
      send_beats(bq, hs);
      repeat (12) @(negedge clk);
      chk($sformatf("oversize%0d_drop", n), 64'(n_drop_p), 64'd1);
      chk($sformatf("oversize%0d_noout", n), 64'(outq.size()), 64'd0);
      chk($sformatf("oversize%0d_nocsum", n), 64'(n_pulse), 64'd0);
    end
    run_frame(mk_frame(42, 64'h1234_0001_0000_0000), "after_drop");
    chk("after_drop_tbl_csum", 64'(last_csum), 64'hEDCA);

    // Reset in the middle of SEND, after beat 2 is accepted.
    make_beats(mk_frame(42, 64'h1234_0001_0000_0000), bq);
    clear_mon();
    send_beats(bq, hs);
    t = 0;
    while (outq.size() < 3 && t < 100) begin @(negedge clk); #1; t++; end
    if (outq.size() < 3) timeout("midsend_beats");
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("midsend_reset");
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("midsend_tready", 64'(s_tready), 64'd1);
    run_frame(mk_frame(42, 64'h1234_0001_0000_0000), "after_reset");
    chk("after_reset_tbl_csum", 64'(last_csum), 64'hEDCA);

    // Random frames with random backpressure.
    rdy_mode = 2;
    for (int f = 0; f < 25; f++) begin
      int len;
      len = $urandom_range(1, 64);
      b = {};
      for (int i = 0; i < len; i++) b.push_back(8'($urandom));
      run_frame(b, $sformatf("rnd%0d_len%0d", f, len));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
